// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and the signed coordinate type
// used by the scanner and by every object block downstream of it.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Internal counters are unsigned; 10 bits covers both 800 and 525.
  localparam int unsigned CNT_W = 10;

  typedef logic signed [10:0] coord_t;

  function automatic int unsigned sync_start(input int unsigned visible,
                                             input int unsigned front);
    return visible + front;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered sync-window and
// visible-region flags that always describe the count held in the same clk.
module vga_axis_counter #(
  parameter int unsigned TOTAL      = vga_timing_pkg::H_TOTAL,
  parameter int unsigned SYNC_START = vga_timing_pkg::H_SYNC_START,
  parameter int unsigned SYNC_END   = vga_timing_pkg::H_SYNC_END,
  parameter int unsigned VISIBLE    = vga_timing_pkg::H_VISIBLE
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               advance,
  output logic [vga_timing_pkg::CNT_W-1:0]   count,
  output logic                               wrap,
  output logic                               inSync,
  output logic                               inVisible
);
  import vga_timing_pkg::*;

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SS     = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SE     = CNT_W'(SYNC_END);
  localparam logic [CNT_W-1:0] VIS    = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] count_p0;
  logic [CNT_W-1:0] count_nxt;
  logic             in_sync_p0;
  logic             in_vis_p0;
  logic             wrap_c;

  always_comb begin
    wrap_c    = (count_p0 == LAST);
    count_nxt = wrap_c ? '0 : count_p0 + ONE;
  end

  // Stage p0: flags are decoded from the next count so they land together
  // with it, keeping sync/blank aligned to the presented coordinate.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_p0   <= '0;
      in_sync_p0 <= 1'b0;
      in_vis_p0  <= 1'b1;
    end else if (advance) begin
      count_p0   <= count_nxt;
      in_sync_p0 <= (count_nxt >= SS) && (count_nxt <= SE);
      in_vis_p0  <= (count_nxt < VIS);
    end
  end

  assign count     = count_p0;
  assign wrap      = wrap_c;
  assign inSync    = in_sync_p0;
  assign inVisible = in_vis_p0;

endmodule

// File: rtl/vga_pixel_scanner.sv
// VGA raster timing generator: coordinates, syncs, blanking and frame strobe.
// Define PIXEL_CLK_DIV2_EN to advance the scan on alternate clks (50 MHz clk).
module vga_pixel_scanner #(
  parameter int unsigned H_VISIBLE       = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT         = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC          = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK          = vga_timing_pkg::H_BACK,
  parameter int unsigned V_VISIBLE       = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT         = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC          = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK          = vga_timing_pkg::V_BACK,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               resetN,
  output logic signed [10:0] pixelX,
  output logic signed [10:0] pixelY,
  output logic               hSync,
  output logic               vSync,
  output logic               blankN,
  output logic               startOfFrame,
  output logic               pixelTick
);
  import vga_timing_pkg::*;

  localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SS  = sync_start(H_VISIBLE, H_FRONT);
  localparam int unsigned H_SE  = H_SS + H_SYNC - 1;
  localparam int unsigned V_SS  = sync_start(V_VISIBLE, V_FRONT);
  localparam int unsigned V_SE  = V_SS + V_SYNC - 1;

  logic             advance;
  logic             tick_p0;
  logic             sof_p0;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             h_wrap, v_wrap;
  logic             h_sync, v_sync;
  logic             h_vis, v_vis;

`ifdef PIXEL_CLK_DIV2_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) tick_p0 <= 1'b0;
    else         tick_p0 <= ~tick_p0;
  end
  assign advance = tick_p0;
`else
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) tick_p0 <= 1'b0;
    else         tick_p0 <= 1'b1;
  end
  assign advance = 1'b1;
`endif

  vga_axis_counter #(
    .TOTAL(H_TOT), .SYNC_START(H_SS), .SYNC_END(H_SE), .VISIBLE(H_VISIBLE)
  ) u_h (
    .clk(clk), .resetN(resetN), .advance(advance),
    .count(h_count), .wrap(h_wrap), .inSync(h_sync), .inVisible(h_vis)
  );

  vga_axis_counter #(
    .TOTAL(V_TOT), .SYNC_START(V_SS), .SYNC_END(V_SE), .VISIBLE(V_VISIBLE)
  ) u_v (
    .clk(clk), .resetN(resetN), .advance(h_wrap & advance),
    .count(v_count), .wrap(v_wrap), .inSync(v_sync), .inVisible(v_vis)
  );

  // Stage p0: strobe lands with the (0,0) produced by a frame wrap and is
  // cleared on the next clk, so it stays one clk wide even when divided.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) sof_p0 <= 1'b0;
    else         sof_p0 <= advance & h_wrap & v_wrap;
  end

  assign pixelX       = coord_t'({1'b0, h_count});
  assign pixelY       = coord_t'({1'b0, v_count});
  assign hSync        = h_sync ^ SYNC_ACTIVE_LOW;
  assign vSync        = v_sync ^ SYNC_ACTIVE_LOW;
  assign blankN       = h_vis & v_vis;
  assign startOfFrame = sof_p0;
  assign pixelTick    = tick_p0;

endmodule
